credit_receiver_fifo: RTL and testbench

CREDIT_RECEIVER_FIFO -- requirements
Module: credit_receiver_fifo

---
 rtl/credit_receiver_fifo.sv | 87 ++++++++
 tb/tb_credit_receiver_fifo.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/credit_receiver_fifo.sv
// Credit-based receive FIFO: buffers interconnect flits and presents them show-ahead to the pearl.
// Latency: a flit pushed at edge N is visible after N and poppable at N+1; the credit pulse follows each pop by one cycle.
// Backpressure: none toward the interconnect (credits guarantee space); a push into a full FIFO is dropped and sets sticky o_overflow.
module credit_receiver_fifo #(
    parameter int DATA_WIDTH = 17,
    parameter int DEPTH      = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        i_data,
    input  logic                         i_valid,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic                         o_increment_count,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_overflow
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic                  increment_q;
    logic                  overflow_q;
    logic                  full;
    logic                  pop;
    logic                  push_ok;
    logic                  overflow_evt;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // A pop frees the head entry in the same edge, so a full FIFO can still take a push alongside it.
    always_comb begin
        full         = (count == FULL_CNT);
        pop          = (count != '0) && i_ready;
        push_ok      = i_valid && (!full || pop);
        overflow_evt = i_valid && full && !pop;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            increment_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            increment_q <= pop;
            if (overflow_evt) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset; only pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (!reset && push_ok) begin
            mem[wr_ptr] <= i_data;
        end
    end

    assign o_data            = mem[rd_ptr];
    assign o_valid           = (count != '0);
    assign o_count           = count;
    assign o_increment_count = increment_q;
    assign o_overflow        = overflow_q;

endmodule

// File: tb/tb_credit_receiver_fifo.sv
// Directed bench for credit_receiver_fifo: a DEPTH=8 instance for latency, fill/drain, full and reset cases,
// and a DEPTH=5 instance driven through a fixed push/pop pattern against a queue model for wrap-around.
module tb_credit_receiver_fifo;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic [16:0] a_data  = '0;
    logic        a_valid = 1'b0;
    logic        a_ready = 1'b0;
    logic [16:0] a_odata;
    logic        a_ovalid;
    logic        a_inc;
    logic [3:0]  a_count;
    logic        a_ovf;

    logic [16:0] b_data  = '0;
    logic        b_valid = 1'b0;
    logic        b_ready = 1'b0;
    logic [16:0] b_odata;
    logic        b_ovalid;
    logic        b_inc;
    logic [2:0]  b_count;
    logic        b_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    credit_receiver_fifo #(.DATA_WIDTH(17), .DEPTH(8)) dut_a (
        .clock(clock), .reset(reset),
        .i_data(a_data), .i_valid(a_valid),
        .o_data(a_odata), .o_valid(a_ovalid), .i_ready(a_ready),
        .o_increment_count(a_inc), .o_count(a_count), .o_overflow(a_ovf)
    );

    credit_receiver_fifo #(.DATA_WIDTH(17), .DEPTH(5)) dut_b (
        .clock(clock), .reset(reset),
        .i_data(b_data), .i_valid(b_valid),
        .o_data(b_odata), .o_valid(b_ovalid), .i_ready(b_ready),
        .o_increment_count(b_inc), .o_count(b_count), .o_overflow(b_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fill_a(input int n);
        a_ready = 1'b0;
        for (int i = 1; i <= n; i++) begin
            a_valid = 1'b1;
            a_data  = 17'(i);
            tick();
        end
        a_valid = 1'b0;
    endtask

    logic [19:0] pat_push;
    logic [19:0] pat_pop;
    logic [16:0] model_q[$];
    int          pops_total;
    int          pushes_total;
    int          inc_total;
    logic        pop_now;
    logic        push_now;

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_count", 32'(a_count), 0);
        chk("rst_valid", 32'(a_ovalid), 0);
        chk("rst_inc", 32'(a_inc), 0);
        chk("rst_ovf", 32'(a_ovf), 0);
        chk("rst_count_b", 32'(b_count), 0);
        reset = 1'b0;

        // Basic latency
        a_valid = 1'b1;
        a_data  = 17'h00ABC;
        a_ready = 1'b1;
        tick();
        a_valid = 1'b0;
        chk("lat_valid", 32'(a_ovalid), 1);
        chk("lat_data", 32'(a_odata), 32'h00ABC);
        chk("lat_count1", 32'(a_count), 1);
        chk("lat_inc_early", 32'(a_inc), 0);
        tick();
        chk("lat_inc", 32'(a_inc), 1);
        chk("lat_count0", 32'(a_count), 0);
        chk("lat_valid0", 32'(a_ovalid), 0);
        tick();
        chk("lat_inc_single", 32'(a_inc), 0);

        // Fill and drain
        fill_a(8);
        chk("fill_count", 32'(a_count), 8);
        chk("fill_ovf", 32'(a_ovf), 0);
        chk("fill_head", 32'(a_odata), 1);
        a_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_data", 32'(a_odata), 32'(i));
            tick();
            chk("drain_inc", 32'(a_inc), 1);
        end
        chk("drain_count", 32'(a_count), 0);
        chk("drain_valid", 32'(a_ovalid), 0);
        tick();
        chk("empty_ready_inc", 32'(a_inc), 0);
        chk("empty_ready_count", 32'(a_count), 0);

        // Full with simultaneous push and pop
        fill_a(8);
        a_valid = 1'b1;
        a_data  = 17'd9;
        a_ready = 1'b1;
        tick();
        a_valid = 1'b0;
        chk("fullpp_count", 32'(a_count), 8);
        chk("fullpp_ovf", 32'(a_ovf), 0);
        chk("fullpp_inc", 32'(a_inc), 1);
        for (int i = 2; i <= 9; i++) begin
            chk("fullpp_data", 32'(a_odata), 32'(i));
            tick();
        end
        chk("fullpp_end_count", 32'(a_count), 0);
        a_ready = 1'b0;
        tick();

        // Overflow: push into full without pop
        fill_a(8);
        a_valid = 1'b1;
        a_data  = 17'h1FFFF;
        tick();
        a_valid = 1'b0;
        chk("ovf_flag", 32'(a_ovf), 1);
        chk("ovf_count", 32'(a_count), 8);
        chk("ovf_inc", 32'(a_inc), 0);
        a_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("ovf_data", 32'(a_odata), 32'(i));
            tick();
        end
        chk("ovf_drained_valid", 32'(a_ovalid), 0);
        a_ready = 1'b0;
        tick();
        tick();
        chk("ovf_sticky", 32'(a_ovf), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("ovf_cleared", 32'(a_ovf), 0);

        // Reset mid-operation with a pending credit pulse
        fill_a(3);
        chk("mid_count3", 32'(a_count), 3);
        a_ready = 1'b1;
        tick();
        chk("mid_inc_before", 32'(a_inc), 1);
        chk("mid_count2", 32'(a_count), 2);
        reset   = 1'b1;
        a_valid = 1'b1;
        a_data  = 17'h0055;
        tick();
        chk("mid_inc", 32'(a_inc), 0);
        chk("mid_valid", 32'(a_ovalid), 0);
        chk("mid_count", 32'(a_count), 0);
        tick();
        chk("mid_hold_count", 32'(a_count), 0);
        chk("mid_hold_inc", 32'(a_inc), 0);
        reset   = 1'b0;
        a_valid = 1'b0;
        a_ready = 1'b0;
        tick();
        chk("mid_post_count", 32'(a_count), 0);

        // Wrap-around through DEPTH=5 against a queue model
        pat_push     = 20'b1110_1111_0110_1101_1111;
        pat_pop      = 20'b0101_1010_1101_0011_0000;
        pops_total   = 0;
        pushes_total = 0;
        inc_total    = 0;
        for (int i = 0; i < 28; i++) begin
            logic p_bit;
            logic r_bit;
            p_bit    = (i < 20) ? pat_push[i] : 1'b0;
            r_bit    = (i < 20) ? pat_pop[i] : 1'b1;
            pop_now  = r_bit && (model_q.size() > 0);
            push_now = p_bit && ((model_q.size() < 5) || pop_now);
            if (pop_now) begin
                chk("wrap_data", 32'(b_odata), 32'(model_q[0]));
            end
            b_ready = r_bit;
            b_valid = push_now;
            b_data  = 17'(32'h100 + i);
            tick();
            if (pop_now) begin
                void'(model_q.pop_front());
                pops_total++;
            end
            if (push_now) begin
                model_q.push_back(17'(32'h100 + i));
                pushes_total++;
            end
            if (b_inc) begin
                inc_total++;
            end
            chk("wrap_count", 32'(b_count), 32'(model_q.size()));
            chk("wrap_inc", 32'(b_inc), 32'(pop_now));
        end
        b_valid = 1'b0;
        b_ready = 1'b0;
        chk("wrap_inc_total", 32'(inc_total), 32'(pops_total));
        chk("wrap_all_out", 32'(pops_total), 32'(pushes_total));
        chk("wrap_ovf", 32'(b_ovf), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
